prog_loader: RTL

//   Boot-time program loader upstream of progmem/cpu. Takes a byte stream (e.g. from a UART rx) over valid/ready.

---
 rtl/prog_loader.sv | 130 +++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Boot loader: parses a 16-bit big-endian length, streams payload bytes into progmem and releases cpu reset when done.
// Optional trailing XOR checksum byte enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int SIZE   = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              write,
  output logic [ADDR_W-1:0] writeaddr,
  output logic [7:0]        writevalue,
  output logic              cpu_rst,
  output logic              done,
  output logic              error,
  output logic [15:0]       loaded
);

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, RUN, ERROR, CHECK} state_t;
  localparam state_t AFTER_PAYLOAD = CHECK;
`else
  typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, RUN, ERROR} state_t;
  localparam state_t AFTER_PAYLOAD = RUN;
`endif

  localparam logic [16:0] SIZE_L = 17'(SIZE);

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       loaded_q, loaded_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] writeaddr_q, writeaddr_d;
  logic [7:0]        writevalue_q, writevalue_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              accept;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  assign rx_ready = (state_q != RUN) && (state_q != ERROR);
  assign accept   = rx_valid && rx_ready;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    loaded_d     = loaded_q;
    write_d      = 1'b0;
    writeaddr_d  = writeaddr_q;
    writevalue_d = writevalue_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    // Status outputs lag the state by one cycle so the last write lands before the cpu wakes.
    cpu_rst_d    = (state_q != RUN);
    done_d       = (state_q == RUN);
    error_d      = (state_q == ERROR);
    if (accept) begin
      case (state_q)
        LEN_HI: begin
          len_d   = {rx_data, len_q[7:0]};
          state_d = LEN_LO;
        end
        LEN_LO: begin
          len_d = {len_q[15:8], rx_data};
          if ({1'b0, len_d} > SIZE_L)  state_d = ERROR;
          else if (len_d == 16'd0)     state_d = AFTER_PAYLOAD;
          else                         state_d = DATA;
        end
        DATA: begin
          write_d      = 1'b1;
          writeaddr_d  = loaded_q[ADDR_W-1:0];
          writevalue_d = rx_data;
          loaded_d     = loaded_q + 16'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d       = csum_q ^ rx_data;
`endif
          if (loaded_d == len_q) state_d = AFTER_PAYLOAD;
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        CHECK: state_d = (rx_data == csum_q) ? RUN : ERROR;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LEN_HI;
      len_q        <= 16'd0;
      loaded_q     <= 16'd0;
      write_q      <= 1'b0;
      writeaddr_q  <= '0;
      writevalue_q <= 8'd0;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q       <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      loaded_q     <= loaded_d;
      write_q      <= write_d;
      writeaddr_q  <= writeaddr_d;
      writevalue_q <= writevalue_d;
      cpu_rst_q    <= cpu_rst_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign write      = write_q;
  assign writeaddr  = writeaddr_q;
  assign writevalue = writevalue_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign error      = error_q;
  assign loaded     = loaded_q;

endmodule
